// File: rtl/intersection_ctrl.sv
// Four-way intersection phase sequencer: STRAIGHT, TURN and PED phases separated by
// all-red CLEAR intervals, serving latched pedestrian and left-turn requests.
module intersection_ctrl #(
    parameter int GREEN_MIN  = 8,
    parameter int TURN_TIME  = 6,
    parameter int PED_TIME   = 10,
    parameter int CLEAR_TIME = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pedestrian_button,
    input  logic turn_sensor,
    output logic pedestrian_green,
    output logic up_green,
    output logic down_green,
    output logic turn_green
);

    // state    | meaning
    // STRAIGHT | up/down through green, waits GREEN_MIN before serving requests
    // TURN     | protected left turn from up direction, with up through green
    // PED      | walk signal, all vehicle greens off
    // CLEAR    | all red for CLEAR_TIME cycles, then enters next_phase
    typedef enum logic [1:0] {
        ST_STRAIGHT,
        ST_TURN,
        ST_PED,
        ST_CLEAR
    } phase_t;

    localparam logic [7:0] GREEN_LAST = 8'(GREEN_MIN - 1);
    localparam logic [7:0] TURN_LAST  = 8'(TURN_TIME - 1);
    localparam logic [7:0] PED_LAST   = 8'(PED_TIME - 1);
    localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_TIME - 1);

    phase_t     state;
    phase_t     next_phase;
    logic [7:0] timer;
    logic       ped_req;
    logic       turn_req;
    logic       ped_eff;
    logic       turn_eff;
    logic       entering_ped;
    logic       entering_turn;

    assign ped_eff       = ped_req | pedestrian_button;
    assign turn_eff      = turn_req | turn_sensor;
    assign entering_ped  = (state == ST_CLEAR) && (timer == CLEAR_LAST) && (next_phase == ST_PED);
    assign entering_turn = (state == ST_CLEAR) && (timer == CLEAR_LAST) && (next_phase == ST_TURN);

    // {pedestrian, up, down, turn}
    function automatic logic [3:0] lights_for(input phase_t p);
        case (p)
            ST_STRAIGHT: lights_for = 4'b0110;
            ST_TURN:     lights_for = 4'b0101;
            ST_PED:      lights_for = 4'b1000;
            default:     lights_for = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_CLEAR;
            next_phase <= ST_STRAIGHT;
            timer      <= '0;
            ped_req    <= 1'b0;
            turn_req   <= 1'b0;
            {pedestrian_green, up_green, down_green, turn_green} <= 4'b0000;
        end else begin
            // A press during a phase's own service is already covered, except on its final cycle.
            if (entering_ped)
                ped_req <= 1'b0;
            else if (state == ST_PED)
                ped_req <= ped_req | (pedestrian_button & (timer == PED_LAST));
            else
                ped_req <= ped_req | pedestrian_button;

            if (entering_turn)
                turn_req <= 1'b0;
            else if (state == ST_TURN)
                turn_req <= turn_req | (turn_sensor & (timer == TURN_LAST));
            else
                turn_req <= turn_req | turn_sensor;

            case (state)
                ST_STRAIGHT: begin
                    if (timer != GREEN_LAST) begin
                        timer <= timer + 8'd1;
                    end else if (turn_eff) begin
                        state      <= ST_CLEAR;
                        next_phase <= ST_TURN;
                        timer      <= '0;
                        {pedestrian_green, up_green, down_green, turn_green} <= 4'b0000;
                    end else if (ped_eff) begin
                        state      <= ST_CLEAR;
                        next_phase <= ST_PED;
                        timer      <= '0;
                        {pedestrian_green, up_green, down_green, turn_green} <= 4'b0000;
                    end
                end
                ST_TURN: begin
                    if (timer == TURN_LAST) begin
                        state      <= ST_CLEAR;
                        next_phase <= ped_eff ? ST_PED : ST_STRAIGHT;
                        timer      <= '0;
                        {pedestrian_green, up_green, down_green, turn_green} <= 4'b0000;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_PED: begin
                    if (timer == PED_LAST) begin
                        state      <= ST_CLEAR;
                        next_phase <= ST_STRAIGHT;
                        timer      <= '0;
                        {pedestrian_green, up_green, down_green, turn_green} <= 4'b0000;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_CLEAR: begin
                    if (timer == CLEAR_LAST) begin
                        state <= next_phase;
                        timer <= '0;
                        {pedestrian_green, up_green, down_green, turn_green} <= lights_for(next_phase);
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
